// File: rtl/fifo_reader.sv
// ----------------------------------------------------------------------------
// fifo_reader: drains a FIFO with one-cycle read latency into a 2-entry
// output buffer with valid/ready handshake. Option: FIFO_READER_CNT_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_reader #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  enable,
  input  logic                  Fifo_Empty,
  input  logic                  Almost_Empty,
  input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
  input  logic                  ready_in,
  output logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] buffer [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  deq;
  logic [2:0]            occ_proj;

  // Projected occupancy once the word already in flight lands.
  always_comb begin
    deq       = valid_out & ready_in;
    occ_proj  = {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};
    valid_out = (occ != 2'd0);
    data_out  = buffer[rd_ptr];
    busy      = (state == RUN) || (state == DRAIN);
    pop       = (state == RUN) & ~Fifo_Empty & (occ_proj < 3'd2)
              & ~(Almost_Empty & inflight);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable)
          state_nxt = RUN;
        else if (!inflight && (occ == 2'd0))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      buffer[0] <= '0;
      buffer[1] <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      occ       <= 2'd0;
      inflight  <= 1'b0;
    end else begin
      inflight <= pop;
      if (inflight) begin
        buffer[wr_ptr] <= Fifo_Data_in;
        wr_ptr         <= ~wr_ptr;
      end
      if (deq)
        rd_ptr <= ~rd_ptr;
      case ({inflight, deq})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef FIFO_READER_CNT_EN
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)
      cnt <= '0;
    else if (deq)
      cnt <= cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  assign word_cnt = cnt;
`else
  assign word_cnt = '0;
`endif

endmodule

`default_nettype wire
